// File: rtl/sh_mem_xbar_pkg.sv
// rtl/sh_mem_xbar_pkg.sv - shared request codes, FSM states and defaults for sh_mem_xbar
// Purpose: request encodings, copy-engine state encodings and a request decode helper
//          imported by the crossbar, its interface and its arbiter.
package sh_mem_xbar_pkg;

  localparam int NUM_CORES_DEF  = 4;
  localparam int NUM_BANKS_DEF  = 4;
  localparam int BANK_DEPTH_DEF = 256;
  localparam int DATA_W_DEF     = 8;

  // Per-core {wr,rd} enable codes; 2'b11 is treated as idle.
  typedef enum logic [1:0] {
    REQ_IDLE = 2'b00,
    REQ_RD   = 2'b01,
    REQ_WR   = 2'b10,
    REQ_NOP  = 2'b11
  } req_e;

  typedef enum logic [1:0] {
    CP_IDLE  = 2'b00,
    CP_COPY  = 2'b01,
    CP_DRAIN = 2'b10
  } cp_state_e;

  function automatic logic is_req(input logic [1:0] en);
    return (en == REQ_RD) || (en == REQ_WR);
  endfunction

endpackage

// File: rtl/sh_mem_xbar_if.sv
// rtl/sh_mem_xbar_if.sv - core request and copy-out bus of sh_mem_xbar
// Purpose: bundles the per-core request/ack channels and the copy-out stream.
// master: core array / display side (drives requests, cp_start, cp_window)
// slave : sh_mem_xbar (drives ready, rd_data, cp_*)
// SH_MEM_STALL_CNT_EN adds stall_cnt (16 bits per core).
interface sh_mem_xbar_if #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 256,
  parameter int DATA_W     = 8
);
  localparam int ADDR_W = $clog2(NUM_BANKS) + $clog2(BANK_DEPTH);

  logic [2*NUM_CORES-1:0]      enable;
  logic [ADDR_W*NUM_CORES-1:0] addr;
  logic [DATA_W*NUM_CORES-1:0] wr_data;
  logic [DATA_W*NUM_CORES-1:0] rd_data;
  logic [NUM_CORES-1:0]        ready;
  logic                        cp_start;
  logic                        cp_window;
  logic                        cp_valid;
  logic [ADDR_W-1:0]           cp_addr;
  logic [DATA_W-1:0]           cp_data;
  logic                        cp_busy;
  logic                        cp_done;
`ifdef SH_MEM_STALL_CNT_EN
  logic [16*NUM_CORES-1:0]     stall_cnt;
`endif

  modport master (
    output enable, addr, wr_data, cp_start, cp_window,
    input  rd_data, ready, cp_valid, cp_addr, cp_data, cp_busy, cp_done
`ifdef SH_MEM_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  enable, addr, wr_data, cp_start, cp_window,
    output rd_data, ready, cp_valid, cp_addr, cp_data, cp_busy, cp_done
`ifdef SH_MEM_STALL_CNT_EN
    , output stall_cnt
`endif
  );

endinterface

// File: rtl/sh_mem_xbar_rr_arb.sv
// rtl/sh_mem_xbar_rr_arb.sv - per-bank round-robin arbiter
// Purpose: grants the first requester at or after the pointer (wrapping);
//          the pointer moves to granted+1 only when a grant is issued.
// Ports: i_clk, i_rst_n (async active-low), i_req (request mask),
//        o_gnt_id (granted core), o_gnt_valid (a grant was issued).
module sh_mem_xbar_rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  output logic [IW-1:0] o_gnt_id,
  output logic          o_gnt_valid
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_id;
  logic          w_found;

  always_comb begin
    w_id    = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[(int'(r_ptr) + k) % N]) begin
        w_found = 1'b1;
        w_id    = IW'((int'(r_ptr) + k) % N);
      end
    end
  end

  assign o_gnt_id    = w_id;
  assign o_gnt_valid = w_found;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (int'(w_id) == N - 1) ? '0 : w_id + IW'(1);
    end
  end

endmodule

// File: rtl/sh_mem_xbar.sv
// rtl/sh_mem_xbar.sv - banked shared memory with per-bank round-robin and copy-out engine
// Purpose: NUM_CORES request channels onto NUM_BANKS single-port banks; a copy engine
//          streams the whole address space out while cp_window is high.
// Ports: i_clk, i_reset (async active-low), bus (sh_mem_xbar_if.slave).
// Option: SH_MEM_STALL_CNT_EN adds per-core saturating stall counters on bus.stall_cnt.
module sh_mem_xbar
  import sh_mem_xbar_pkg::*;
#(
  parameter int NUM_CORES  = NUM_CORES_DEF,
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int BANK_DEPTH = BANK_DEPTH_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input logic          i_clk,
  input logic          i_reset,
  sh_mem_xbar_if.slave bus
);

  localparam int BANK_ID_W = $clog2(NUM_BANKS);
  localparam int WORD_W    = $clog2(BANK_DEPTH);
  localparam int ADDR_W    = BANK_ID_W + WORD_W;
  localparam int CORE_ID_W = $clog2(NUM_CORES);

  logic [DATA_W-1:0]    r_mem [NUM_BANKS][BANK_DEPTH];

  logic [NUM_CORES-1:0] w_valid, w_is_wr, w_gnt, w_ready;
  logic [BANK_ID_W-1:0] w_bank  [NUM_CORES];
  logic [WORD_W-1:0]    w_word  [NUM_CORES];
  logic [DATA_W-1:0]    w_wdata [NUM_CORES];
  logic [NUM_CORES-1:0] w_req_mask [NUM_BANKS];
  logic [CORE_ID_W-1:0] w_gnt_id   [NUM_BANKS];
  logic [NUM_BANKS-1:0] w_gnt_valid;

  logic [NUM_CORES-1:0] r_rd_ack;
  logic [DATA_W-1:0]    r_rd_data [NUM_CORES];

  cp_state_e            r_cp_state;
  logic [ADDR_W-1:0]    r_cp_ptr, r_cp_addr;
  logic [DATA_W-1:0]    r_cp_data;
  logic                 r_cp_valid, r_cp_busy, r_cp_done;
  logic                 w_cp_rd;
  logic [BANK_ID_W-1:0] w_cp_bank;
  logic [WORD_W-1:0]    w_cp_word;

  assign w_cp_rd   = (r_cp_state == CP_COPY) && bus.cp_window;
  assign w_cp_bank = r_cp_ptr[ADDR_W-1 -: BANK_ID_W];
  assign w_cp_word = r_cp_ptr[WORD_W-1:0];

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_valid[i] = is_req(bus.enable[2*i +: 2]);
      w_is_wr[i] = (bus.enable[2*i +: 2] == REQ_WR);
      w_bank[i]  = bus.addr[ADDR_W*i + WORD_W +: BANK_ID_W];
      w_word[i]  = bus.addr[ADDR_W*i +: WORD_W];
      w_wdata[i] = bus.wr_data[DATA_W*i +: DATA_W];
    end
  end

  // The engine owns its bank outright this cycle: masking the requests means the
  // arbiter issues no grant and its pointer stays put, so the blocked core retries as-is.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_req_mask[b] = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        w_req_mask[b][i] = w_valid[i] && (w_bank[i] == BANK_ID_W'(b)) &&
                           !(w_cp_rd && (w_cp_bank == BANK_ID_W'(b)));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
    sh_mem_xbar_rr_arb #(.N(NUM_CORES), .IW(CORE_ID_W)) u_arb (
      .i_clk       (i_clk),
      .i_rst_n     (i_reset),
      .i_req       (w_req_mask[b]),
      .o_gnt_id    (w_gnt_id[b]),
      .o_gnt_valid (w_gnt_valid[b])
    );
  end

  // Writes ack in the grant cycle; reads ack one cycle later from r_rd_ack.
  always_comb begin
    w_gnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_gnt_valid[b] && (w_gnt_id[b] == CORE_ID_W'(i))) w_gnt[i] = 1'b1;
      end
    end
    w_ready = r_rd_ack | (w_gnt & w_is_wr);
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_gnt[i] && w_is_wr[i]) r_mem[w_bank[i]][w_word[i]] <= w_wdata[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rd_ack <= '0;
      for (int i = 0; i < NUM_CORES; i++) r_rd_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_rd_ack[i]  <= w_gnt[i] && !w_is_wr[i];
        r_rd_data[i] <= (w_gnt[i] && !w_is_wr[i]) ? r_mem[w_bank[i]][w_word[i]] : '0;
      end
    end
  end

  // Copy engine: COPY walks ptr over the full address space while the window is
  // open; DRAIN covers the cycle in which the last word is presented.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cp_state <= CP_IDLE;
      r_cp_ptr   <= '0;
      r_cp_addr  <= '0;
      r_cp_data  <= '0;
      r_cp_valid <= 1'b0;
      r_cp_busy  <= 1'b0;
      r_cp_done  <= 1'b0;
    end else begin
      r_cp_valid <= w_cp_rd;
      r_cp_done  <= 1'b0;
      if (w_cp_rd) begin
        r_cp_addr <= r_cp_ptr;
        r_cp_data <= r_mem[w_cp_bank][w_cp_word];
      end
      case (r_cp_state)
        CP_IDLE: if (bus.cp_start) begin
          r_cp_state <= CP_COPY;
          r_cp_ptr   <= '0;
          r_cp_busy  <= 1'b1;
        end
        CP_COPY: if (bus.cp_window) begin
          r_cp_ptr <= r_cp_ptr + ADDR_W'(1);
          if (r_cp_ptr == '1) r_cp_state <= CP_DRAIN;
        end
        CP_DRAIN: begin
          r_cp_state <= CP_IDLE;
          r_cp_busy  <= 1'b0;
          r_cp_done  <= 1'b1;
        end
        default: r_cp_state <= CP_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ready   = w_ready;
    bus.rd_data = '0;
    for (int i = 0; i < NUM_CORES; i++) bus.rd_data[DATA_W*i +: DATA_W] = r_rd_data[i];
  end

  assign bus.cp_valid = r_cp_valid;
  assign bus.cp_addr  = r_cp_addr;
  assign bus.cp_data  = r_cp_data;
  assign bus.cp_busy  = r_cp_busy;
  assign bus.cp_done  = r_cp_done;

`ifdef SH_MEM_STALL_CNT_EN
  // Waiting cycles only: the read issue cycle is granted, so it never counts.
  logic [15:0] r_stall [NUM_CORES];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_CORES; i++) r_stall[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_valid[i] && !w_gnt[i] && !w_ready[i] && (r_stall[i] != 16'hFFFF))
          r_stall[i] <= r_stall[i] + 16'd1;
      end
    end
  end

  always_comb begin
    bus.stall_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) bus.stall_cnt[16*i +: 16] = r_stall[i];
  end
`endif

endmodule

// File: tb/tb_sh_mem_xbar.sv
// tb/tb_sh_mem_xbar.sv - directed self-checking bench for sh_mem_xbar
module tb_sh_mem_xbar;

  localparam int NC = 4;
  localparam int NB = 4;
  localparam int BD = 256;
  localparam int DW = 8;
  localparam logic [9:0] Z = 10'h000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sh_mem_xbar_if #(.NUM_CORES(NC), .NUM_BANKS(NB), .BANK_DEPTH(BD), .DATA_W(DW)) bus ();

  sh_mem_xbar #(.NUM_CORES(NC), .NUM_BANKS(NB), .BANK_DEPTH(BD), .DATA_W(DW)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  en;
    logic [39:0] addr;
    logic [31:0] wd;
    logic [3:0]  rdy;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [39:0] a4(input logic [9:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.enable    = '0;
    bus.addr      = '0;
    bus.wr_data   = '0;
    bus.cp_start  = 1'b0;
    bus.cp_window = 1'b0;
  endtask

  // Core i writes bank i: address k gets k & 0xFF.
  task automatic preload();
    for (int w = 0; w < 256; w++) begin
      @(posedge clk); #1;
      bus.enable  = 8'b10_10_10_10;
      bus.addr    = a4(10'(768 + w), 10'(512 + w), 10'(256 + w), 10'(w));
      bus.wr_data = {4{8'(w)}};
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Full copy with a cycle model of the engine and, optionally, core1 reading 0x2AB every cycle.
  task automatic run_copy(input bit toggle, input bit hammer, input string tag);
    int st = 0, beats = 0, dones = 0, tail = 0;
    logic [9:0] ptr = '0, pptr = '0;
    bit prd = 0, pgnt = 0, pdone = 0, win, erd, gnt, fin = 0;
    for (int cyc = 0; cyc < 4000 && tail < 3; cyc++) begin
      @(posedge clk); #1;
      win           = toggle ? ((cyc / 5) % 2 == 0) : 1'b1;
      bus.cp_start  = (cyc == 0);
      bus.cp_window = win;
      bus.enable    = hammer ? 8'b00_00_01_00 : 8'h00;
      bus.addr      = a4(Z, Z, 10'h2AB, Z);
      @(negedge clk);
      chk($sformatf("%s cp_valid c%0d", tag, cyc), bus.cp_valid, prd);
      if (prd) begin
        beats++;
        chk($sformatf("%s cp_addr c%0d", tag, cyc), bus.cp_addr, pptr);
        chk($sformatf("%s cp_data c%0d", tag, cyc), bus.cp_data, pptr[7:0]);
      end
      chk($sformatf("%s cp_busy c%0d", tag, cyc), bus.cp_busy, st != 0);
      chk($sformatf("%s cp_done c%0d", tag, cyc), bus.cp_done, pdone);
      if (bus.cp_done) dones++;
      chk($sformatf("%s ready c%0d", tag, cyc), bus.ready, {2'b00, pgnt, 1'b0});
      chk($sformatf("%s rd_data c%0d", tag, cyc), bus.rd_data, pgnt ? 32'h0000AB00 : 32'h0);
      erd   = (st == 1) && win;
      gnt   = hammer && !(erd && ptr[9:8] == 2'd2);
      pdone = (st == 2);
      prd   = erd;
      pptr  = ptr;
      pgnt  = gnt;
      if (st == 0 && cyc == 0) begin
        st = 1; ptr = '0;
      end else if (st == 1 && win) begin
        if (ptr == 10'h3FF) st = 2;
        ptr = ptr + 10'd1;
      end else if (st == 2) begin
        st = 0; fin = 1;
      end
      if (fin) tail++;
    end
    @(posedge clk); #1;
    idle_inputs();
    chk($sformatf("%s beat count", tag), beats, 1024);
    chk($sformatf("%s done count", tag), dones, 1);
  endtask

  initial begin
    bit bad;
    idle_inputs();

    vecs[0]  = '{8'b00_00_00_10, a4(Z, Z, Z, 10'h005),                   32'h000000A5, 4'b0001, 32'h00000000};
    vecs[1]  = '{8'b00_00_00_01, a4(Z, Z, Z, 10'h005),                   32'h00000000, 4'b0000, 32'h00000000};
    vecs[2]  = '{8'b00_00_00_00, a4(Z, Z, Z, Z),                         32'h00000000, 4'b0001, 32'h000000A5};
    vecs[3]  = '{8'b10_10_10_10, a4(10'h310, 10'h210, 10'h110, 10'h010), 32'h44332211, 4'b1111, 32'h00000000};
    vecs[4]  = '{8'b01_01_01_01, a4(10'h310, 10'h210, 10'h110, 10'h010), 32'h00000000, 4'b0000, 32'h00000000};
    vecs[5]  = '{8'b00_00_00_00, a4(Z, Z, Z, Z),                         32'h00000000, 4'b1111, 32'h44332211};
    vecs[6]  = '{8'b01_01_01_01, a4(10'h310, 10'h310, 10'h310, 10'h310), 32'h00000000, 4'b0000, 32'h00000000};
    vecs[7]  = '{8'b01_01_01_01, a4(10'h310, 10'h310, 10'h310, 10'h310), 32'h00000000, 4'b0001, 32'h00000044};
    vecs[8]  = '{8'b01_01_01_01, a4(10'h310, 10'h310, 10'h310, 10'h310), 32'h00000000, 4'b0010, 32'h00004400};
    vecs[9]  = '{8'b01_01_01_01, a4(10'h310, 10'h310, 10'h310, 10'h310), 32'h00000000, 4'b0100, 32'h00440000};
    vecs[10] = '{8'b01_01_01_01, a4(10'h310, 10'h310, 10'h310, 10'h310), 32'h00000000, 4'b1000, 32'h44000000};
    vecs[11] = '{8'b00_00_00_00, a4(Z, Z, Z, Z),                         32'h00000000, 4'b0001, 32'h00000044};
    vecs[12] = '{8'b00_10_10_00, a4(Z, 10'h021, 10'h020, Z),             32'h006B5A00, 4'b0010, 32'h00000000};
    vecs[13] = '{8'b00_10_10_00, a4(Z, 10'h021, 10'h020, Z),             32'h006B5A00, 4'b0100, 32'h00000000};
    vecs[14] = '{8'b00_01_01_00, a4(Z, 10'h021, 10'h020, Z),             32'h00000000, 4'b0000, 32'h00000000};
    vecs[15] = '{8'b00_01_01_00, a4(Z, 10'h021, 10'h020, Z),             32'h00000000, 4'b0010, 32'h00005A00};
    vecs[16] = '{8'b00_00_00_00, a4(Z, Z, Z, Z),                         32'h00000000, 4'b0100, 32'h006B0000};
    vecs[17] = '{8'b11_11_11_11, a4(Z, Z, Z, Z),                         32'hFFFFFFFF, 4'b0000, 32'h00000000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", bus.ready, 4'b0000);
    chk("reset rd_data", bus.rd_data, 32'h0);
    chk("reset cp_valid", bus.cp_valid, 1'b0);
    chk("reset cp_busy", bus.cp_busy, 1'b0);
    chk("reset cp_done", bus.cp_done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int v = 0; v < 18; v++) begin
      @(posedge clk); #1;
      bus.enable  = vecs[v].en;
      bus.addr    = vecs[v].addr;
      bus.wr_data = vecs[v].wd;
      @(negedge clk);
      chk($sformatf("vec%0d ready", v), bus.ready, vecs[v].rdy);
      chk($sformatf("vec%0d rd_data", v), bus.rd_data, vecs[v].rd);
    end
    @(posedge clk); #1;
    idle_inputs();

    preload();
    run_copy(1'b0, 1'b0, "copy");
    run_copy(1'b1, 1'b1, "window");

    // Reset mid-copy (ptr=300) with a core1 read ack outstanding.
    @(posedge clk); #1;
    bus.cp_start = 1'b1; bus.cp_window = 1'b1;
    @(posedge clk); #1;
    bus.cp_start = 1'b0;
    bus.enable   = 8'b00_00_01_00;
    bus.addr     = a4(Z, Z, 10'h2AB, Z);
    repeat (300) begin @(posedge clk); #1; end
    chk("pre-reset cp_valid", bus.cp_valid, 1'b1);
    chk("pre-reset cp_addr", bus.cp_addr, 10'd299);
    chk("pre-reset ready", bus.ready, 4'b0010);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("mid reset cp_busy", bus.cp_busy, 1'b0);
    chk("mid reset cp_valid", bus.cp_valid, 1'b0);
    chk("mid reset ready", bus.ready, 4'b0000);
    chk("mid reset rd_data", bus.rd_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.cp_done || bus.cp_busy || bus.cp_valid) bad = 1;
    end
    chk("no done/busy after reset", bad, 1'b0);

    preload();
    run_copy(1'b0, 1'b0, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
